// File: rtl/pattern_gen.sv
// Pixel source behind the VGA timing generator. Produces 24-bit RGB from a
// selectable test pattern (colour bars, grey ramp, checkerboard, bouncing box)
// and delays syncs/DE through a 2-stage colour pipeline.
// Ports:
//   clk, reset                 pixel clock, synchronous active-high reset
//   in_h_sync/in_v_sync/in_de  timing from generator
//   in_x, in_y                 active-area column/row (valid when in_de=1)
//   in_frame                   one-cycle end-of-frame pulse (mode load, box step)
//   mode                       pattern select, sampled on in_frame
//   out_h_sync/out_v_sync/out_de  inputs delayed 2 cycles
//   out_data                   {R,G,B}, aligned with out_de
module pattern_gen #(
  parameter int unsigned WIDTH    = 800,
  parameter int unsigned HEIGHT   = 600,
  parameter int unsigned BOX_SIZE = 64,
  parameter int unsigned STEP     = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_h_sync,
  input  logic                      in_v_sync,
  input  logic                      in_de,
  input  logic [$clog2(WIDTH)-1:0]  in_x,
  input  logic [$clog2(HEIGHT)-1:0] in_y,
  input  logic                      in_frame,
  input  logic [1:0]                mode,
  output logic                      out_h_sync,
  output logic                      out_v_sync,
  output logic                      out_de,
  output logic [23:0]               out_data
);

  localparam int unsigned XW    = $clog2(WIDTH);
  localparam int unsigned YW    = $clog2(HEIGHT);
  localparam int unsigned XW1   = XW + 1;
  localparam int unsigned YW1   = YW + 1;
  localparam int unsigned BAR_W = WIDTH / 8;
  localparam int unsigned X_MAX = WIDTH - BOX_SIZE;
  localparam int unsigned Y_MAX = HEIGHT - BOX_SIZE;

  // Frame-rate state
  logic [1:0]    mode_q;
  logic [XW-1:0] box_x_q, box_x_d;
  logic [YW-1:0] box_y_q, box_y_d;
  logic          dir_x_q, dir_x_d;
  logic          dir_y_q, dir_y_d;

  // Stage 1 registers
  logic          hs1_q, vs1_q, de1_q;
  logic [2:0]    bar_q, bar_d;
  logic          hit_q, hit_d;
  logic          border_q, border_d;
  logic          checker_q, checker_d;
  logic [7:0]    grey_q, grey_d;

  // Stage 2 colour
  logic [23:0]   data_d;

  logic [XW1-1:0] x_sum;
  logic [YW1-1:0] y_sum;
  logic [XW-1:0]  bar_div;
  logic [15:0]    x_ext, y_ext;

  // Box bounce: one step per frame, clamped to the active area
  always_comb begin
    box_x_d = box_x_q;
    box_y_d = box_y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    x_sum   = XW1'(box_x_q) + XW1'(STEP);
    y_sum   = YW1'(box_y_q) + YW1'(STEP);
    if (!dir_x_q) begin
      if (x_sum >= XW1'(X_MAX)) begin
        box_x_d = XW'(X_MAX);
        dir_x_d = 1'b1;
      end else begin
        box_x_d = x_sum[XW-1:0];
      end
    end else if (box_x_q <= XW'(STEP)) begin
      box_x_d = '0;
      dir_x_d = 1'b0;
    end else begin
      box_x_d = box_x_q - XW'(STEP);
    end
    if (!dir_y_q) begin
      if (y_sum >= YW1'(Y_MAX)) begin
        box_y_d = YW'(Y_MAX);
        dir_y_d = 1'b1;
      end else begin
        box_y_d = y_sum[YW-1:0];
      end
    end else if (box_y_q <= YW'(STEP)) begin
      box_y_d = '0;
      dir_y_d = 1'b0;
    end else begin
      box_y_d = box_y_q - YW'(STEP);
    end
  end

  // Stage 1: bar index and per-pixel flags
  always_comb begin
    x_ext     = 16'(in_x);
    y_ext     = 16'(in_y);
    bar_div   = in_x / XW'(BAR_W);
    bar_d     = (bar_div > XW'(7)) ? 3'd7 : bar_div[2:0];
    hit_d     = (in_x >= box_x_q) && (XW1'(in_x) < XW1'(box_x_q) + XW1'(BOX_SIZE)) &&
                (in_y >= box_y_q) && (YW1'(in_y) < YW1'(box_y_q) + YW1'(BOX_SIZE));
    border_d  = (in_x == '0) || (in_x == XW'(WIDTH - 1)) ||
                (in_y == '0) || (in_y == YW'(HEIGHT - 1));
    checker_d = x_ext[5] ^ y_ext[5];
    grey_d    = x_ext[7:0];
  end

  // Stage 2: colour select; blanking forces black since x/y wrap there
  always_comb begin
    data_d = '0;
    case (mode_q)
      2'd0:    data_d = {{8{~bar_q[1]}}, {8{~bar_q[2]}}, {8{~bar_q[0]}}};
      2'd1:    data_d = {grey_q, grey_q, grey_q};
      2'd2:    data_d = checker_q ? 24'hFFFFFF : 24'h000000;
      default: data_d = border_q ? 24'hFF0000 : (hit_q ? 24'hFFFFFF : 24'h000000);
    endcase
    if (!de1_q) data_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q     <= '0;
      box_x_q    <= '0;
      box_y_q    <= '0;
      dir_x_q    <= 1'b0;
      dir_y_q    <= 1'b0;
      hs1_q      <= 1'b0;
      vs1_q      <= 1'b0;
      de1_q      <= 1'b0;
      bar_q      <= '0;
      hit_q      <= 1'b0;
      border_q   <= 1'b0;
      checker_q  <= 1'b0;
      grey_q     <= '0;
      out_h_sync <= 1'b0;
      out_v_sync <= 1'b0;
      out_de     <= 1'b0;
      out_data   <= '0;
    end else begin
      if (in_frame) begin
        mode_q  <= mode;
        box_x_q <= box_x_d;
        box_y_q <= box_y_d;
        dir_x_q <= dir_x_d;
        dir_y_q <= dir_y_d;
      end
      hs1_q      <= in_h_sync;
      vs1_q      <= in_v_sync;
      de1_q      <= in_de;
      bar_q      <= bar_d;
      hit_q      <= hit_d;
      border_q   <= border_d;
      checker_q  <= checker_d;
      grey_q     <= grey_d;
      out_h_sync <= hs1_q;
      out_v_sync <= vs1_q;
      out_de     <= de1_q;
      out_data   <= data_d;
    end
  end

endmodule
